v810_exc_seq: RTL and testbench
===============================

Name: v810_exc_seq

Overview:
Exception/interrupt entry sequencer for the V810 core. It sits directly upstream of the system register file.
- Arbitrates synchronous exceptions, NMI and maskable interrupts at instruction boundaries.
- Drives the sysreg write port (WA/WD/WE) to save PC and PSW into EIPC/EIPSW or FEPC/FEPSW.
- Drives ECR_CC with ECR_SET_EICC/ECR_SET_FECC, and PSW_SET/PSW_RESET.
- Issues a handler vector to the fetch stage.

Parameters:
DUP_VECTOR, 32'hFFFFFFD0, handler address for duplexed exceptions and NMI
NMI_CODE, 16'hFFD0, exception code loaded into ECR.FECC on NMI

Ports:
CLK  in  1  clock
RESn  in  1  reset, asynchronous, active-low
CE  in  1  global clock enable; all state advances only when CE=1
PSW  in  32  current PSW from sysreg
BOUNDARY  in  1  pipeline is at an instruction boundary; requests may be accepted
EXC_REQ  in  1  synchronous exception request (trap, illegal opcode, divide-by-zero, ...)
EXC_CODE  in  16  exception code for EXC_REQ
EXC_PC  in  32  PC to save for EXC_REQ
NEXT_PC  in  32  restart PC to save for NMI/INT
NMI  in  1  non-maskable interrupt, rising-edge sensitive
INT_REQ  in  1  maskable interrupt request, level
INT_LEVEL  in  4  interrupt level
EXC_ACK / NMI_ACK / INT_ACK  out  1 each  acceptance pulse
BUSY  out  1  sequence in progress; pipeline stalls
WA  out  5  sysreg write address (SRSEL_* codes)
WD  out  32  sysreg write data
WE  out  1  sysreg write enable
PSW_SET  out  32  PSW bits to set
PSW_RESET  out  32  PSW bits to clear
ECR_CC  out  16  cause code
ECR_SET_EICC  out  1  load ECR.EICC
ECR_SET_FECC  out  1  load ECR.FECC
VEC_VALID  out  1  one-cycle redirect strobe
VEC_PC  out  32  handler address
HALT  out  1  fatal exception; core halted

Behaviour:
- PSW fields used: ID=bit12, AE=bit13, EP=bit14, NP=bit15, I=bits19:16.
- Reset (RESn=0, asynchronous): state=IDLE, nmi_pend=0, HALT=0, all other outputs 0. The same applies if reset asserts mid-sequence; outputs clear immediately.
- NMI edge detect: register NMI on CE cycles. A rising edge sets nmi_pend. NMI acceptance clears it; a simultaneous new edge wins (pend stays 1).
- Arbitration in IDLE, CE=1, BOUNDARY=1. Priority: EXC_REQ > nmi_pend > INT_REQ. Only the selected source's ACK pulses, combinationally, in the accept cycle.
  - EXC_REQ:
    - PSW.NP=1 -> FATAL.
    - else PSW.EP=1 -> FE path: code=EXC_CODE, vector=DUP_VECTOR.
    - else EI path: code=EXC_CODE, vector={16'hFFFF, EXC_CODE[15:4], 4'h0}.
  - nmi_pend: accepted only if PSW.NP=0; otherwise it stays pending. FE path: code=NMI_CODE, vector=DUP_VECTOR.
  - INT_REQ: accepted only if ID=0, EP=0, NP=0 and INT_LEVEL>=PSW.I. Unaccepted INT is not latched. EI path: code=16'hFE00|(L<<4), vector=32'hFFFFFE00|(L<<4).
- Accept snapshots the saved PC (EXC_PC or NEXT_PC), PSW, code, vector and path.
- States: IDLE -> SAVE_PC -> SAVE_PSW -> VECTOR -> IDLE; FATAL is terminal until reset. BUSY=1 whenever state!=IDLE.
- SAVE_PC: WE=1, WA=SRSEL_EIPC (EI) or SRSEL_FEPC (FE), WD=saved PC.
- SAVE_PSW:
  - WE=1, WA=SRSEL_EIPSW or SRSEL_FEPSW, WD=snapshot PSW.
  - ECR_CC=code, with ECR_SET_EICC (EI) or ECR_SET_FECC (FE).
  - EI: PSW_SET=0x5000, PSW_RESET=0x2000.
  - FE: PSW_SET=0x9000, PSW_RESET=0x2000.
  - INT additionally: PSW_RESET|=0xF0000, PSW_SET|=min(L+1,15)<<16.
- VECTOR: VEC_VALID=1, VEC_PC=vector.
- Outside their states, WE, ECR_SET_*, PSW_SET/RESET and VEC_VALID are 0. WA/WD/ECR_CC/VEC_PC are 0 when their qualifying strobe is 0.
- FATAL: HALT=1, no sysreg writes, no ACKs, BUSY=1.
- CE=0 freezes state; strobes are qualified by the consumer's CE.
- Latency: accept to VEC_VALID = 3 CE cycles.

Test Plan:
- INT: PSW=0, INT_LEVEL=5, NEXT_PC=0x07000100. Expected: INT_ACK; then WA=EIPC, WD=0x07000100; then WA=EIPSW, WD=0, ECR_CC=0xFE50 with SET_EICC, PSW_SET=0x00065000, PSW_RESET=0x000F2000; then VEC_PC=0xFFFFFE50.
- Masking: PSW.I=7 with level 5, or PSW=0x1000 (ID=1). Expected: no INT_ACK and BUSY=0. INT_LEVEL=15 with I=0 -> PSW_SET=0x000F5000.
- Trap: EXC_CODE=0xFFA3, EXC_PC=0x100, PSW=0. Expected: EIPC=0x100, EICC=0xFFA3, VEC_PC=0xFFFFFFA0.
- Duplexed: PSW=0x4000, EXC_CODE=0xFF80. Expected: FEPC/FEPSW written, FECC=0xFF80, PSW_SET=0x9000, VEC_PC=0xFFFFFFD0.
- Simultaneous EXC + NMI edge + INT in one cycle. Expected: EXC handled first; NMI taken at the next BOUNDARY with FECC=0xFFD0; INT is not acked.
- EXC with PSW=0x8000. Expected: HALT=1, no WE, held until reset. RESn low during SAVE_PSW -> all outputs 0 immediately; nmi_pend cleared.

Source files
------------

// File: rtl/v810_exc_seq.sv
// V810 exception/interrupt entry sequencer.
// Accepts EXC/NMI/INT at instruction boundaries. It then saves PC and PSW
// through the sysreg write port, loads ECR and PSW, and issues the handler vector.
module v810_exc_seq #(
  parameter logic [31:0] DUP_VECTOR = 32'hFFFF_FFD0,
  parameter logic [15:0] NMI_CODE   = 16'hFFD0
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [31:0] PSW,
  input  logic        BOUNDARY,
  input  logic        EXC_REQ,
  input  logic [15:0] EXC_CODE,
  input  logic [31:0] EXC_PC,
  input  logic [31:0] NEXT_PC,
  input  logic        NMI,
  input  logic        INT_REQ,
  input  logic [3:0]  INT_LEVEL,
  output logic        EXC_ACK,
  output logic        NMI_ACK,
  output logic        INT_ACK,
  output logic        BUSY,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic        WE,
  output logic [31:0] PSW_SET,
  output logic [31:0] PSW_RESET,
  output logic [15:0] ECR_CC,
  output logic        ECR_SET_EICC,
  output logic        ECR_SET_FECC,
  output logic        VEC_VALID,
  output logic [31:0] VEC_PC,
  output logic        HALT
);

  // System register select codes for the save slots
  localparam logic [4:0] SRSEL_EIPC  = 5'd0;
  localparam logic [4:0] SRSEL_EIPSW = 5'd1;
  localparam logic [4:0] SRSEL_FEPC  = 5'd2;
  localparam logic [4:0] SRSEL_FEPSW = 5'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE_PC, S_SAVE_PSW, S_VECTOR, S_FATAL
  } state_t;

  state_t      state;
  logic        nmi_q;
  logic        nmi_pend;
  logic [31:0] psw_s;
  logic [15:0] code_s;
  logic [31:0] vec_s;
  logic        fe_s;
  logic [31:0] set_s;
  logic [31:0] reset_s;

  logic        psw_id, psw_ep, psw_np;
  logic [3:0]  psw_i;
  logic        arb_en, exc_sel, nmi_sel, int_sel, nmi_go, int_ok;
  logic [3:0]  int_new_i;

  logic        acc_fe;
  logic [31:0] acc_pc;
  logic [15:0] acc_code;
  logic [31:0] acc_vec;
  logic [31:0] acc_set;
  logic [31:0] acc_reset;

  assign psw_id = PSW[12];
  assign psw_ep = PSW[14];
  assign psw_np = PSW[15];
  assign psw_i  = PSW[19:16];

  // Arbitration happens only in IDLE, at a boundary, on an enabled cycle.
  // An NMI is blocked while NP is set. In that case it stays pending and does not take priority over INT.
  assign arb_en    = RESn & CE & BOUNDARY & (state == S_IDLE);
  assign nmi_go    = nmi_pend & ~psw_np;
  assign int_ok    = ~psw_id & ~psw_ep & ~psw_np & (INT_LEVEL >= psw_i);
  assign exc_sel   = arb_en & EXC_REQ;
  assign nmi_sel   = arb_en & ~EXC_REQ & nmi_go;
  assign int_sel   = arb_en & ~EXC_REQ & ~nmi_go & INT_REQ & int_ok;
  assign int_new_i = (INT_LEVEL == 4'hF) ? 4'hF : INT_LEVEL + 4'd1;

  assign EXC_ACK = exc_sel;
  assign NMI_ACK = nmi_sel;
  assign INT_ACK = int_sel;
  assign BUSY    = (state != S_IDLE);

  // Snapshot values for whichever source wins arbitration this cycle
  always_comb begin
    acc_fe    = 1'b0;
    acc_pc    = NEXT_PC;
    acc_code  = 16'h0000;
    acc_vec   = 32'h0;
    acc_set   = 32'h0000_5000;
    acc_reset = 32'h0000_2000;
    if (exc_sel) begin
      acc_pc   = EXC_PC;
      acc_code = EXC_CODE;
      if (psw_ep) begin
        acc_fe  = 1'b1;
        acc_vec = DUP_VECTOR;
        acc_set = 32'h0000_9000;
      end else begin
        acc_vec = {16'hFFFF, EXC_CODE[15:4], 4'h0};
      end
    end else if (nmi_sel) begin
      acc_fe   = 1'b1;
      acc_code = NMI_CODE;
      acc_vec  = DUP_VECTOR;
      acc_set  = 32'h0000_9000;
    end else begin
      acc_code  = 16'hFE00 | {8'h00, INT_LEVEL, 4'h0};
      acc_vec   = 32'hFFFF_FE00 | {24'h0, INT_LEVEL, 4'h0};
      acc_set   = 32'h0000_5000 | {12'h0, int_new_i, 16'h0};
      acc_reset = 32'h000F_2000;
    end
  end

  // Sequencer FSM with NMI edge capture and registered sysreg/ECR/PSW/vector outputs
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state        <= S_IDLE;
      nmi_q        <= 1'b0;
      nmi_pend     <= 1'b0;
      psw_s        <= 32'h0;
      code_s       <= 16'h0;
      vec_s        <= 32'h0;
      fe_s         <= 1'b0;
      set_s        <= 32'h0;
      reset_s      <= 32'h0;
      WA           <= 5'd0;
      WD           <= 32'h0;
      WE           <= 1'b0;
      PSW_SET      <= 32'h0;
      PSW_RESET    <= 32'h0;
      ECR_CC       <= 16'h0;
      ECR_SET_EICC <= 1'b0;
      ECR_SET_FECC <= 1'b0;
      VEC_VALID    <= 1'b0;
      VEC_PC       <= 32'h0;
      HALT         <= 1'b0;
    end else if (CE) begin
      nmi_q <= NMI;
      // A new rising edge beats the clear from an acceptance in the same cycle
      if (NMI && !nmi_q)
        nmi_pend <= 1'b1;
      else if (nmi_sel)
        nmi_pend <= 1'b0;

      WA           <= 5'd0;
      WD           <= 32'h0;
      WE           <= 1'b0;
      PSW_SET      <= 32'h0;
      PSW_RESET    <= 32'h0;
      ECR_CC       <= 16'h0;
      ECR_SET_EICC <= 1'b0;
      ECR_SET_FECC <= 1'b0;
      VEC_VALID    <= 1'b0;
      VEC_PC       <= 32'h0;

      case (state)
        S_IDLE: begin
          if (exc_sel && psw_np) begin
            state <= S_FATAL;
            HALT  <= 1'b1;
          end else if (exc_sel || nmi_sel || int_sel) begin
            state   <= S_SAVE_PC;
            psw_s   <= PSW;
            code_s  <= acc_code;
            vec_s   <= acc_vec;
            fe_s    <= acc_fe;
            set_s   <= acc_set;
            reset_s <= acc_reset;
            WE      <= 1'b1;
            WA      <= acc_fe ? SRSEL_FEPC : SRSEL_EIPC;
            WD      <= acc_pc;
          end
        end
        S_SAVE_PC: begin
          state        <= S_SAVE_PSW;
          WE           <= 1'b1;
          WA           <= fe_s ? SRSEL_FEPSW : SRSEL_EIPSW;
          WD           <= psw_s;
          ECR_CC       <= code_s;
          ECR_SET_EICC <= ~fe_s;
          ECR_SET_FECC <= fe_s;
          PSW_SET      <= set_s;
          PSW_RESET    <= reset_s;
        end
        S_SAVE_PSW: begin
          state     <= S_VECTOR;
          VEC_VALID <= 1'b1;
          VEC_PC    <= vec_s;
        end
        S_VECTOR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_FATAL;
          HALT  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v810_exc_seq.sv
// Self-checking bench for v810_exc_seq: directed scenarios plus randomized traffic
// checked every cycle against a transaction-schedule reference model.
module tb_v810_exc_seq;

  logic        CLK = 1'b0;
  logic        RESn, CE, BOUNDARY, EXC_REQ, NMI, INT_REQ;
  logic [31:0] PSW, EXC_PC, NEXT_PC;
  logic [15:0] EXC_CODE;
  logic [3:0]  INT_LEVEL;
  logic        EXC_ACK, NMI_ACK, INT_ACK, BUSY, WE, ECR_SET_EICC, ECR_SET_FECC, VEC_VALID, HALT;
  logic [4:0]  WA;
  logic [31:0] WD, PSW_SET, PSW_RESET, VEC_PC;
  logic [15:0] ECR_CC;

  int n_cmp = 0;
  int n_bad = 0;

  v810_exc_seq dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .PSW(PSW), .BOUNDARY(BOUNDARY),
    .EXC_REQ(EXC_REQ), .EXC_CODE(EXC_CODE), .EXC_PC(EXC_PC), .NEXT_PC(NEXT_PC),
    .NMI(NMI), .INT_REQ(INT_REQ), .INT_LEVEL(INT_LEVEL),
    .EXC_ACK(EXC_ACK), .NMI_ACK(NMI_ACK), .INT_ACK(INT_ACK), .BUSY(BUSY),
    .WA(WA), .WD(WD), .WE(WE), .PSW_SET(PSW_SET), .PSW_RESET(PSW_RESET),
    .ECR_CC(ECR_CC), .ECR_SET_EICC(ECR_SET_EICC), .ECR_SET_FECC(ECR_SET_FECC),
    .VEC_VALID(VEC_VALID), .VEC_PC(VEC_PC), .HALT(HALT)
  );

  always #5 CLK = ~CLK;

  // One expected output cycle of an entry sequence
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [15:0] cc;
    logic        eicc;
    logic        fecc;
    logic [31:0] pset;
    logic [31:0] preset;
    logic        vv;
    logic [31:0] vpc;
  } rec_t;

  rec_t sched[$];
  bit   m_halt = 0;
  bit   m_pend = 0;
  bit   m_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the three output cycles that follow an accepted request
  task automatic push_seq(input string src, input bit fe, input logic [31:0] pc, input logic [31:0] psw,
                          input logic [15:0] code, input logic [31:0] vec,
                          input logic [31:0] pset, input logic [31:0] preset);
    rec_t r;
    r = '{default: '0};
    r.we = 1; r.wa = fe ? 5'd2 : 5'd0; r.wd = pc;
    sched.push_back(r);
    r = '{default: '0};
    r.we = 1; r.wa = fe ? 5'd3 : 5'd1; r.wd = psw; r.cc = code;
    r.eicc = !fe; r.fecc = fe; r.pset = pset; r.preset = preset;
    sched.push_back(r);
    r = '{default: '0};
    r.vv = 1; r.vpc = vec;
    sched.push_back(r);
    $display("accept %s pc=%h psw=%h code=%h vec=%h", src, pc, psw, code, vec);
  endtask

  // Reference model and per-cycle comparison
  always @(negedge CLK) begin
    rec_t cur;
    bit   busy, arb, eacc, nacc, iacc, np, ep, id;
    int   ni;
    cur = '{default: '0};
    if (!RESn) begin
      sched.delete();
      m_halt = 0; m_pend = 0; m_prev = 0;
      chk("rst_busy", BUSY, 0); chk("rst_halt", HALT, 0); chk("rst_we", WE, 0);
      chk("rst_wa", WA, 0); chk("rst_wd", WD, 0); chk("rst_pset", PSW_SET, 0);
      chk("rst_preset", PSW_RESET, 0); chk("rst_cc", ECR_CC, 0);
      chk("rst_eicc", ECR_SET_EICC, 0); chk("rst_fecc", ECR_SET_FECC, 0);
      chk("rst_vv", VEC_VALID, 0); chk("rst_vpc", VEC_PC, 0);
      chk("rst_acks", {EXC_ACK, NMI_ACK, INT_ACK}, 0);
    end else begin
      np = PSW[15]; ep = PSW[14]; id = PSW[12];
      busy = (sched.size() != 0) || m_halt;
      arb  = CE && BOUNDARY && !busy;
      eacc = arb && EXC_REQ;
      nacc = arb && !EXC_REQ && m_pend && !np;
      iacc = arb && !EXC_REQ && !(m_pend && !np) && INT_REQ && !id && !ep && !np
             && (INT_LEVEL >= PSW[19:16]);
      if (sched.size() != 0) cur = sched[0];
      chk("exc_ack", EXC_ACK, eacc); chk("nmi_ack", NMI_ACK, nacc); chk("int_ack", INT_ACK, iacc);
      chk("busy", BUSY, busy); chk("halt", HALT, m_halt);
      chk("we", WE, cur.we); chk("wa", WA, cur.wa); chk("wd", WD, cur.wd);
      chk("ecr_cc", ECR_CC, cur.cc); chk("set_eicc", ECR_SET_EICC, cur.eicc);
      chk("set_fecc", ECR_SET_FECC, cur.fecc); chk("psw_set", PSW_SET, cur.pset);
      chk("psw_reset", PSW_RESET, cur.preset); chk("vec_valid", VEC_VALID, cur.vv);
      chk("vec_pc", VEC_PC, cur.vpc);
      if (CE) begin
        if (sched.size() != 0) void'(sched.pop_front());
        if (NMI && !m_prev) m_pend = 1;
        else if (nacc) m_pend = 0;
        m_prev = NMI;
        if (eacc) begin
          if (np) begin
            m_halt = 1;
            $display("accept EXC fatal code=%h", EXC_CODE);
          end else if (ep)
            push_seq("EXC-FE", 1, EXC_PC, PSW, EXC_CODE, 32'hFFFF_FFD0, 32'h9000, 32'h2000);
          else
            push_seq("EXC-EI", 0, EXC_PC, PSW, EXC_CODE, 32'hFFFF_0000 + (EXC_CODE / 16) * 16,
                     32'h5000, 32'h2000);
        end else if (nacc) begin
          push_seq("NMI", 1, NEXT_PC, PSW, 16'hFFD0, 32'hFFFF_FFD0, 32'h9000, 32'h2000);
        end else if (iacc) begin
          ni = int'(INT_LEVEL) + 1;
          if (ni > 15) ni = 15;
          push_seq("INT", 0, NEXT_PC, PSW, 16'hFE00 + 16'(INT_LEVEL) * 16,
                   32'hFFFF_FE00 + 32'(INT_LEVEL) * 16, 32'h5000 + 32'(ni) * 65536, 32'hF2000);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESn = 0; CE = 1; BOUNDARY = 1; EXC_REQ = 0; NMI = 0; INT_REQ = 0;
    PSW = 0; EXC_PC = 0; NEXT_PC = 0; EXC_CODE = 0; INT_LEVEL = 0;
    #2;
    chk("lit_reset_busy", BUSY, 0); chk("lit_reset_halt", HALT, 0); chk("lit_reset_vv", VEC_VALID, 0);
    tick(); tick();
    RESn = 1;
    tick();

    // Maskable interrupt, level 5
    PSW = 0; INT_LEVEL = 5; NEXT_PC = 32'h0700_0100; INT_REQ = 1; #1;
    chk("lit_int_ack", INT_ACK, 1);
    tick(); INT_REQ = 0;
    chk("lit_int_we", WE, 1); chk("lit_int_wa_pc", WA, 0); chk("lit_int_wd_pc", WD, 32'h0700_0100);
    tick();
    chk("lit_int_wa_psw", WA, 1); chk("lit_int_wd_psw", WD, 0); chk("lit_int_cc", ECR_CC, 16'hFE50);
    chk("lit_int_eicc", ECR_SET_EICC, 1); chk("lit_int_pset", PSW_SET, 32'h0006_5000);
    chk("lit_int_preset", PSW_RESET, 32'h000F_2000);
    tick();
    chk("lit_int_vv", VEC_VALID, 1); chk("lit_int_vpc", VEC_PC, 32'hFFFF_FE50);
    tick();
    chk("lit_int_idle", BUSY, 0);

    // Masking by level and by ID, then saturation of the new level
    PSW = 32'h0007_0000; INT_LEVEL = 5; INT_REQ = 1; #1;
    chk("lit_mask_lvl_ack", INT_ACK, 0);
    tick(); chk("lit_mask_lvl_busy", BUSY, 0);
    PSW = 32'h0000_1000; #1;
    chk("lit_mask_id_ack", INT_ACK, 0);
    tick(); chk("lit_mask_id_busy", BUSY, 0);
    PSW = 0; INT_LEVEL = 15; #1;
    chk("lit_int15_ack", INT_ACK, 1);
    tick(); INT_REQ = 0;
    tick(); chk("lit_int15_pset", PSW_SET, 32'h000F_5000);
    tick(); tick();

    // Trap on the EI path
    PSW = 0; EXC_CODE = 16'hFFA3; EXC_PC = 32'h100; EXC_REQ = 1; #1;
    chk("lit_trap_ack", EXC_ACK, 1);
    tick(); EXC_REQ = 0;
    chk("lit_trap_wa", WA, 0); chk("lit_trap_wd", WD, 32'h100);
    tick(); chk("lit_trap_cc", ECR_CC, 16'hFFA3); chk("lit_trap_eicc", ECR_SET_EICC, 1);
    tick(); chk("lit_trap_vpc", VEC_PC, 32'hFFFF_FFA0);
    tick();

    // Duplexed exception on the FE path
    PSW = 32'h4000; EXC_CODE = 16'hFF80; EXC_REQ = 1;
    tick(); EXC_REQ = 0;
    chk("lit_dup_wa_pc", WA, 2);
    tick();
    chk("lit_dup_wa_psw", WA, 3); chk("lit_dup_wd", WD, 32'h4000); chk("lit_dup_fecc", ECR_SET_FECC, 1);
    chk("lit_dup_cc", ECR_CC, 16'hFF80); chk("lit_dup_pset", PSW_SET, 32'h9000);
    tick(); chk("lit_dup_vpc", VEC_PC, 32'hFFFF_FFD0);
    tick();

    // EXC, NMI edge and INT together: EXC first, NMI next, INT never
    PSW = 0; EXC_CODE = 16'hFFA3; NMI = 1; EXC_REQ = 1; INT_REQ = 1; INT_LEVEL = 3;
    NEXT_PC = 32'h0000_2468; #1;
    chk("lit_sim_exc_ack", EXC_ACK, 1); chk("lit_sim_nmi_ack0", NMI_ACK, 0); chk("lit_sim_int_ack0", INT_ACK, 0);
    tick(); EXC_REQ = 0;
    tick(); tick(); tick();
    chk("lit_sim_nmi_ack", NMI_ACK, 1); chk("lit_sim_int_ack1", INT_ACK, 0);
    tick(); INT_REQ = 0; NMI = 0;
    chk("lit_nmi_wa", WA, 2); chk("lit_nmi_wd", WD, 32'h0000_2468);
    tick(); chk("lit_nmi_cc", ECR_CC, 16'hFFD0); chk("lit_nmi_fecc", ECR_SET_FECC, 1);
    tick(); chk("lit_nmi_vpc", VEC_PC, 32'hFFFF_FFD0);
    tick(); chk("lit_nmi_cleared", NMI_ACK, 0);

    // Fatal exception with NP set
    PSW = 32'h8000; EXC_REQ = 1;
    tick(); EXC_REQ = 0;
    chk("lit_fatal_halt", HALT, 1); chk("lit_fatal_we", WE, 0); chk("lit_fatal_busy", BUSY, 1);
    PSW = 0; INT_REQ = 1;
    tick(); tick();
    chk("lit_fatal_hold", HALT, 1); chk("lit_fatal_noack", INT_ACK, 0);
    INT_REQ = 0; RESn = 0; #1;
    chk("lit_fatal_rst", HALT, 0);
    tick(); RESn = 1;
    tick();

    // Reset during SAVE_PSW with an NMI pending
    PSW = 0; INT_LEVEL = 2; INT_REQ = 1;
    tick(); INT_REQ = 0; NMI = 1;
    tick(); chk("lit_mid_we", WE, 1);
    RESn = 0; NMI = 0; #1;
    chk("lit_mid_we0", WE, 0); chk("lit_mid_pset0", PSW_SET, 0); chk("lit_mid_eicc0", ECR_SET_EICC, 0);
    chk("lit_mid_busy0", BUSY, 0); chk("lit_mid_wa0", WA, 0);
    tick(); RESn = 1; #1;
    chk("lit_mid_nmi_ack", NMI_ACK, 0);
    tick(); chk("lit_mid_nmi_ack2", NMI_ACK, 0); chk("lit_mid_busy", BUSY, 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      CE        = ($urandom_range(0, 9) != 0);
      BOUNDARY  = ($urandom_range(0, 3) != 0);
      EXC_REQ   = ($urandom_range(0, 11) == 0);
      EXC_CODE  = 16'($urandom);
      EXC_PC    = $urandom;
      NEXT_PC   = $urandom;
      if ($urandom_range(0, 5) == 0) NMI = ~NMI;
      INT_REQ   = ($urandom_range(0, 2) != 0);
      INT_LEVEL = 4'($urandom);
      PSW       = $urandom & ~32'h8000;
      if ($urandom_range(0, 39) == 0) PSW[15] = 1'b1;
      RESn = !(m_halt && $urandom_range(0, 3) == 0) && ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
